// File: rtl/fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// fifo_wptr_full
// Write-side pointer and full-flag generator for the async CDC FIFO, living in
// the write clock domain. Keeps the binary write address and the registered
// Gray write pointer that is handed to the read-domain synchronizer. The full
// flag is computed from the read pointer already synchronized into this domain.
//
// Optional feature macro: FIFO_ALMOST_FULL_EN
//   When defined, adds the registered walmost_full output. It asserts at an
//   occupancy of AF_LEVEL or more, and also whenever the FIFO is full.
//
// Parameters:
//   ADDR_W   - FIFO address width; depth = 2**ADDR_W, pointers are ADDR_W+1 bits
//   AF_LEVEL - almost-full threshold (1 .. 2**ADDR_W-1)
//
// Ports:
//   clk          in   write-domain clock
//   rst_n        in   asynchronous active-low reset
//   winc         in   write request from the producer
//   wq2_rptr     in   Gray read pointer, synchronized into clk domain
//   waddr        out  binary RAM write address
//   wptr         out  registered Gray write pointer (to synchronizer)
//   wen          out  RAM write enable (winc & ~wfull)
//   wfull        out  registered full flag
//   wovf         out  sticky overflow (write attempted while full)
//   walmost_full out  registered almost-full flag (FIFO_ALMOST_FULL_EN only)
// -----------------------------------------------------------------------------
module fifo_wptr_full #(
   parameter int ADDR_W   = 4,
   parameter int AF_LEVEL = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              winc,
   input  logic [ADDR_W:0]   wq2_rptr,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W:0]   wptr,
   output logic              wen,
   output logic              wfull,
   output logic              wovf
`ifdef FIFO_ALMOST_FULL_EN
   ,
   output logic              walmost_full
`endif
);

   localparam int PW = ADDR_W + 1;

   // Full when the next write pointer equals the read pointer with its two
   // MSBs inverted (Gray-code equivalent of "one lap ahead"). Built as a shift
   // so that ADDR_W=1 naturally inverts both bits.
   localparam logic [ADDR_W:0] FULL_MASK = PW'(3) << (ADDR_W - 1);

   if (AF_LEVEL < 1 || AF_LEVEL > (2 ** ADDR_W) - 1) begin : g_af_level_check
      $error("fifo_wptr_full: AF_LEVEL out of range 1..2**ADDR_W-1");
   end

   logic [ADDR_W:0] r_wbin;
   logic [ADDR_W:0] r_wptr;
   logic            r_wfull;
   logic            r_wovf;

   logic            w_wen;
   logic [ADDR_W:0] w_wbin_next;
   logic [ADDR_W:0] w_wgray_next;
   logic            w_full_next;

   assign w_wen        = winc & ~r_wfull;
   assign w_wbin_next  = r_wbin + PW'(w_wen);
   assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
   assign w_full_next  = (w_wgray_next == (wq2_rptr ^ FULL_MASK));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wbin  <= '0;
         r_wptr  <= '0;
         r_wfull <= 1'b0;
         r_wovf  <= 1'b0;
      end else begin
         r_wbin  <= w_wbin_next;
         r_wptr  <= w_wgray_next;
         r_wfull <= w_full_next;
         r_wovf  <= r_wovf | (winc & r_wfull);
      end
   end

   assign waddr = r_wbin[ADDR_W-1:0];
   assign wptr  = r_wptr;
   assign wen   = w_wen;
   assign wfull = r_wfull;
   assign wovf  = r_wovf;

`ifdef FIFO_ALMOST_FULL_EN
   localparam logic [ADDR_W:0] AF_THRESH = PW'(AF_LEVEL);

   logic [ADDR_W:0] w_rbin_s;
   logic [ADDR_W:0] w_occupancy;
   logic            r_walmost_full;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_rbin_s         = '0;
      w_rbin_s[ADDR_W] = wq2_rptr[ADDR_W];
      for (int unsigned i = 1; i < unsigned'(PW); i++) begin
         w_rbin_s[ADDR_W-i] = w_rbin_s[ADDR_W-i+1] ^ wq2_rptr[ADDR_W-i];
      end
   end

   assign w_occupancy = w_wbin_next - w_rbin_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_walmost_full <= 1'b0;
      end else begin
         r_walmost_full <= (w_occupancy >= AF_THRESH) | w_full_next;
      end
   end

   assign walmost_full = r_walmost_full;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_full
// Scoreboard bench for fifo_wptr_full (ADDR_W=4, AF_LEVEL=12). Each stimulus
// cycle pushes the expected observable state into a queue; a monitor pops and
// compares on the falling clock edge. Expected full is derived from occupancy
// counting rather than the Gray compare used in the design.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_full;

   localparam int AW = 4;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          winc  = 1'b0;
   logic [AW:0]   wq2_rptr = '0;
   logic [AW-1:0] waddr;
   logic [AW:0]   wptr;
   logic          wen;
   logic          wfull;
   logic          wovf;
`ifdef FIFO_ALMOST_FULL_EN
   logic          walmost_full;
`endif

   fifo_wptr_full #(
      .ADDR_W   (AW),
      .AF_LEVEL (12)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .winc     (winc),
      .wq2_rptr (wq2_rptr),
      .waddr    (waddr),
      .wptr     (wptr),
      .wen      (wen),
      .wfull    (wfull),
      .wovf     (wovf)
`ifdef FIFO_ALMOST_FULL_EN
      ,
      .walmost_full (walmost_full)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] wptr;
      logic [3:0] waddr;
      logic       wfull;
      logic       wovf;
      logic       wen;
      logic       waf;
      int         hd;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   // Hand-computed Gray pointer after 0..16 writes.
   logic [4:0] G_TBL [17] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                              5'b00111, 5'b00101, 5'b00100, 5'b01100, 5'b01101,
                              5'b01111, 5'b01110, 5'b01010, 5'b01011, 5'b01001,
                              5'b01000, 5'b11000};
   int         tbl_idx = -1;

   logic [4:0] m_bin  = '0;
   logic       m_full = 1'b0;
   logic       m_ovf  = 1'b0;
   logic       m_af   = 1'b0;
   int         m_hd   = -1;
   logic [4:0] h1, h2;

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs after the rising edge, queue the expected
   // state visible during this cycle, then advance the model across the next edge.
   task automatic step(input logic w, input logic [4:0] rbin);
      exp_t       e;
      logic       wen_m;
      logic [4:0] nb, occ;
      @(posedge clk);
      #1;
      winc     = w;
      wq2_rptr = gray(rbin);
      wen_m    = w & ~m_full;
      e.wptr   = (tbl_idx >= 0) ? G_TBL[tbl_idx] : gray(m_bin);
      e.waddr  = m_bin[3:0];
      e.wfull  = m_full;
      e.wovf   = m_ovf;
      e.wen    = wen_m;
      e.waf    = m_af;
      e.hd     = m_hd;
      sbq.push_back(e);
      nb     = m_bin + {4'b0000, wen_m};
      occ    = nb - rbin;
      m_ovf  = m_ovf | (w & m_full);
      m_full = (occ == 5'd16);
      m_af   = (occ >= 5'd12) | m_full;
      m_hd   = wen_m ? 1 : 0;
      m_bin  = nb;
   endtask

   // Reset asserted between edges; state must read zero before any clock edge.
   task automatic reset_pulse();
      exp_t e;
      @(posedge clk);
      #1;
      winc  = 1'b0;
      rst_n = 1'b0;
      e.wptr = '0; e.waddr = '0; e.wfull = 1'b0; e.wovf = 1'b0;
      e.wen  = 1'b0; e.waf = 1'b0; e.hd = -1;
      sbq.push_back(e);
      m_bin = '0; m_full = 1'b0; m_ovf = 1'b0; m_af = 1'b0; m_hd = 0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      logic [4:0] prev;
      exp_t       e;
      prev = '0;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("wptr",  int'(wptr),  int'(e.wptr));
            chk("waddr", int'(waddr), int'(e.waddr));
            chk("wfull", int'(wfull), int'(e.wfull));
            chk("wovf",  int'(wovf),  int'(e.wovf));
            chk("wen",   int'(wen),   int'(e.wen));
`ifdef FIFO_ALMOST_FULL_EN
            chk("walmost_full", int'(walmost_full), int'(e.waf));
`endif
            if (e.hd >= 0) chk("wptr_hamming", $countones(prev ^ wptr), e.hd);
            prev = wptr;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      reset_pulse();

      // Fill 16 entries with reader parked at 0.
      for (int i = 0; i < 16; i++) begin
         tbl_idx = i;
         step(1'b1, 5'd0);
      end

      // Three writes attempted while full.
      tbl_idx = 16;
      for (int i = 0; i < 3; i++) step(1'b1, 5'd0);
      tbl_idx = -1;

      // Reader advances by one: room for exactly one more write.
      step(1'b0, 5'd1);
      step(1'b1, 5'd1);
      step(1'b0, 5'd1);
      step(1'b0, 5'd1);

      // Wrap-around with a reader lagging two cycles behind.
      reset_pulse();
      h1 = '0;
      h2 = '0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, h2);
         h2 = h1;
         h1 = m_bin;
      end
      step(1'b0, h2);

      // Reset in the middle of a burst.
      reset_pulse();
      for (int i = 0; i < 7; i++) step(1'b1, 5'd0);
      reset_pulse();
      step(1'b1, 5'd0);
      step(1'b0, 5'd0);

`ifdef FIFO_ALMOST_FULL_EN
      reset_pulse();
      for (int i = 0; i < 12; i++) step(1'b1, 5'd0);
      step(1'b0, 5'd2);
      step(1'b0, 5'd2);
`endif

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
